// File: rtl/counter_seq_checker.sv
// Sequence checker for a free-running up-counter: locks onto the observed count and flags illegal steps.
// Optional MISR signature of checked samples is enabled by defining COUNT_CHK_MISR_EN.
module counter_seq_checker #(
  parameter int unsigned            WIDTH     = 4,
  parameter int unsigned            ERR_CNT_W = 8,
  parameter int unsigned            SYNC_LEN  = 2,
  parameter logic [WIDTH-1:0]       MISR_POLY = WIDTH'(4'b0011)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chk_en,
  input  logic                  obs_enable,
  input  logic [WIDTH-1:0]      obs_count,
  input  logic                  clear,
  output logic                  locked,
  output logic                  mismatch,
  output logic                  fail,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WIDTH-1:0]      expected,
  output logic [WIDTH-1:0]      signature,
  output logic [1:0]            dbg_state
);

  localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, SYNC = 2'd2, CHECK = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      prev_count_q;
  logic                  prev_en_q;
  logic [WIDTH-1:0]      predicted;
  logic [WIDTH-1:0]      expected_q, expected_d;
  logic [SYNC_W-1:0]     sync_cnt_q, sync_cnt_d, sync_next;
  logic                  mismatch_q, mismatch_d;
  logic                  fail_q, fail_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  sample_miss;
  logic                  check_sample;

  // Prediction always follows the observed value, so a single jump is flagged only once.
  assign predicted    = prev_en_q ? prev_count_q + WIDTH'(1) : prev_count_q;
  assign sample_miss  = (obs_count != predicted);
  assign check_sample = chk_en && (state_q == CHECK);
  assign sync_next    = sync_cnt_q + SYNC_W'(1);

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    mismatch_d = 1'b0;
    fail_d     = fail_q;
    err_cnt_d  = err_cnt_q;
    expected_d = expected_q;
    case (state_q)
      IDLE: if (chk_en) state_d = SEED;
      SEED: begin
        sync_cnt_d = '0;
        state_d    = SYNC;
      end
      SYNC: begin
        if (sample_miss) begin
          sync_cnt_d = '0;
        end else begin
          sync_cnt_d = sync_next;
          if (sync_next == SYNC_W'(SYNC_LEN)) state_d = CHECK;
        end
      end
      CHECK: begin
        if (sample_miss) begin
          mismatch_d = 1'b1;
          expected_d = predicted;
          fail_d     = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!chk_en) begin
      state_d    = IDLE;
      mismatch_d = 1'b0;
      fail_d     = fail_q;
      err_cnt_d  = err_cnt_q;
      expected_d = expected_q;
    end
    // Clear beats a coincident mismatch: nothing is counted or reported.
    if (clear) begin
      mismatch_d = 1'b0;
      fail_d     = 1'b0;
      err_cnt_d  = '0;
      expected_d = expected_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_count_q <= '0;
      prev_en_q    <= 1'b0;
      sync_cnt_q   <= '0;
      mismatch_q   <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      expected_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= obs_count;
      prev_en_q    <= obs_enable;
      sync_cnt_q   <= sync_cnt_d;
      mismatch_q   <= mismatch_d;
      fail_q       <= fail_d;
      err_cnt_q    <= err_cnt_d;
      expected_q   <= expected_d;
    end
  end

`ifdef COUNT_CHK_MISR_EN
  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (check_sample) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? MISR_POLY : '0) ^ obs_count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  // The polynomial has no effect without the MISR; the signature reads as zero.
  assign signature = MISR_POLY & {WIDTH{1'b0}};
`endif

  assign locked    = (state_q == CHECK);
  assign mismatch  = mismatch_q;
  assign fail      = fail_q;
  assign err_count = err_cnt_q;
  assign expected  = expected_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker: lock, wrap, hold, skip, saturation, clear and signature.
module tb_counter_seq_checker;

  localparam int W  = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          chk_en;
  logic          obs_enable;
  logic [W-1:0]  obs_count;
  logic          clear;
  logic          locked;
  logic          mismatch;
  logic          fail;
  logic [EW-1:0] err_count;
  logic [W-1:0]  expected;
  logic [W-1:0]  signature;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int miss_seen;

  counter_seq_checker #(.WIDTH(W), .ERR_CNT_W(EW), .SYNC_LEN(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .chk_en     (chk_en),
    .obs_enable (obs_enable),
    .obs_count  (obs_count),
    .clear      (clear),
    .locked     (locked),
    .mismatch   (mismatch),
    .fail       (fail),
    .err_count  (err_count),
    .expected   (expected),
    .signature  (signature),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one sample, let it be clocked in, then settle past the edge.
  task automatic drive(input logic en, input logic [W-1:0] cnt);
    obs_enable = en;
    obs_count  = cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_acc(input logic en, input logic [W-1:0] cnt);
    drive(en, cnt);
    miss_seen += int'(mismatch);
  endtask

  initial begin
    reset      = 1'b1;
    chk_en     = 1'b0;
    obs_enable = 1'b0;
    obs_count  = '0;
    clear      = 1'b0;

    for (int i = 0; i < 2; i++) begin
      chk_en = 1'($urandom_range(0, 1));
      clear  = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
    end
    check("rst_locked",    32'(locked),    0);
    check("rst_mismatch",  32'(mismatch),  0);
    check("rst_fail",      32'(fail),      0);
    check("rst_err",       32'(err_count), 0);
    check("rst_expected",  32'(expected),  0);
    check("rst_signature", 32'(signature), 0);
    check("rst_state",     32'(dbg_state), 0);

    reset  = 1'b0;
    clear  = 1'b0;
    chk_en = 1'b1;
    drive(1'b1, 4'd0);
    drive(1'b1, 4'd1);
    drive(1'b1, 4'd2);
    check("lock_early", 32'(locked), 0);
    drive(1'b1, 4'd3);
    check("lock_rise", 32'(locked), 1);

    miss_seen = 0;
    for (int i = 4; i < 18; i++) drive_acc(1'b1, W'(i));
    check("wrap_miss", 32'(miss_seen), 0);
    check("wrap_err",  32'(err_count), 0);

    miss_seen = 0;
    drive_acc(1'b1, 4'd2);
    drive_acc(1'b1, 4'd3);
    drive_acc(1'b1, 4'd4);
    drive_acc(1'b0, 4'd5);
    drive_acc(1'b0, 4'd5);
    drive_acc(1'b0, 4'd5);
    check("hold_miss", 32'(miss_seen), 0);
    drive(1'b1, 4'd6);
    check("step_pulse",    32'(mismatch), 1);
    check("step_expected", 32'(expected), 5);
    check("step_fail",     32'(fail),     1);
    check("step_err",      32'(err_count), 1);

    miss_seen = 0;
    drive_acc(1'b1, 4'd7);
    check("pulse_drop", 32'(mismatch), 0);
    drive_acc(1'b1, 4'd9);
    check("skip_expected", 32'(expected), 8);
    drive_acc(1'b1, 4'd10);
    drive_acc(1'b1, 4'd11);
    check("skip_once", 32'(miss_seen), 1);
    check("skip_err",  32'(err_count), 2);

    miss_seen = 0;
    drive_acc(1'b1, 4'd13);
    drive_acc(1'b1, 4'd15);
    drive_acc(1'b1, 4'd1);
    drive_acc(1'b1, 4'd3);
    drive_acc(1'b1, 4'd5);
    check("sat_pulses", 32'(miss_seen), 5);
    check("sat_err",    32'(err_count), 3);
    check("sat_fail",   32'(fail),      1);

    clear = 1'b1;
    drive(1'b1, 4'd6);
    clear = 1'b0;
    check("clr_err",    32'(err_count), 0);
    check("clr_fail",   32'(fail),      0);
    check("clr_locked", 32'(locked),    1);

    clear = 1'b1;
    drive(1'b1, 4'd9);
    clear = 1'b0;
    check("clr_coinc_err",  32'(err_count), 0);
    check("clr_coinc_miss", 32'(mismatch),  0);
    check("clr_coinc_fail", 32'(fail),      0);

    clear = 1'b1;
    drive(1'b1, 4'd0);
    clear = 1'b0;
    drive(1'b1, 4'd1);
    drive(1'b1, 4'd2);
    drive(1'b1, 4'd3);
`ifdef COUNT_CHK_MISR_EN
    check("misr_sig", 32'(signature), 32'h3);
`else
    check("misr_sig", 32'(signature), 32'h0);
`endif
    check("misr_err", 32'(err_count), 0);

    drive(1'b1, 4'd0);
    check("cut_reset_pulse",    32'(mismatch), 1);
    check("cut_reset_expected", 32'(expected), 4);
    check("cut_reset_err",      32'(err_count), 1);

    chk_en = 1'b0;
    drive(1'b1, 4'd1);
    check("dis_locked", 32'(locked),    0);
    check("dis_state",  32'(dbg_state), 0);
    check("dis_err",    32'(err_count), 1);
    check("dis_fail",   32'(fail),      1);
`ifdef COUNT_CHK_MISR_EN
    check("dis_sig", 32'(signature), 32'h6);
`else
    check("dis_sig", 32'(signature), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_seq_checker.md
Name: counter_seq_checker

Overview:
- Observer/checker for a free-running up-counter: samples the counter's output and enable every cycle and predicts the next value.
- Flags any deviation from the legal count sequence and keeps sticky fail and saturating error-count status for test/BIST readout.
- Sits beside the counter under test, driven from the same clock; purely a reader, it never drives the counter.

Parameters:
- WIDTH, 4, width of the observed counter.
- ERR_CNT_W, 8, width of the saturating error counter.
- SYNC_LEN, 2, consecutive matching samples needed to lock (>=1).
- MISR_POLY, 4'b0011, MISR feedback taps (WIDTH bits; default is x^4+x+1); used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- chk_en  in  1  checker enable.
- obs_enable  in  1  enable seen by the counter under test, same cycle as obs_count.
- obs_count  in  WIDTH  observed counter value.
- clear  in  1  synchronous clear of error status and signature.
- locked  out  1  high while in CHECK.
- mismatch  out  1  one-cycle pulse, registered.
- fail  out  1  sticky error flag.
- err_count  out  ERR_CNT_W  saturating mismatch count.
- expected  out  WIDTH  predicted value for the sample that produced the current mismatch/status.
- signature  out  WIDTH  MISR signature; 0 without the optional feature.

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE; locked, mismatch, fail, err_count, expected, signature, sync_cnt, prev_count, prev_en all 0.
- Every cycle: prev_count<=obs_count and prev_en<=obs_enable.
- predicted = prev_en ? prev_count+1 (mod 2^WIDTH) : prev_count. Wrap 2^WIDTH-1 -> 0 is legal.
- States:
  - IDLE: no compares. chk_en=1 -> SEED.
  - SEED: one capture cycle, no compare; sync_cnt<=0 -> SYNC.
  - SYNC: compare obs_count with predicted. Match: sync_cnt++; at SYNC_LEN matches -> CHECK. Mismatch: sync_cnt<=0, stay in SYNC, not counted as an error.
  - CHECK: locked=1. Mismatch: next cycle mismatch=1 for one cycle, expected=predicted, fail<=1, err_count++ saturating at all-ones. Stay in CHECK; next prediction comes from the observed value, so one jump is flagged once.
- chk_en=0 in any state -> IDLE next cycle; locked drops. fail, err_count and signature are retained.
- Latency: mismatch and expected appear 1 cycle after the offending sample.
- clear (when not in reset): zeros err_count, fail, mismatch and signature; state and lock unaffected. clear and a mismatch in the same cycle: clear wins, the mismatch is not counted.
- A reset of the counter under test mid-run (unexpected 0) is an ordinary mismatch.

Optional Feature:
- Macro: COUNT_CHK_MISR_EN.
- Defined: MISR compacts obs_count on every CHECK-state sample: sig <= (sig<<1) ^ (sig[WIDTH-1] ? MISR_POLY : 0) ^ obs_count. Held outside CHECK; zeroed by reset and clear.
- Undefined: no MISR registers; signature tied to 0.

Test Plan:
- Reset: reset=1 for 2 cycles with random inputs -> all outputs 0, locked=0.
- Lock and wrap (WIDTH=4, SYNC_LEN=2): chk_en=1, obs_enable=1, obs_count 0,1,2,... -> locked rises after SEED + 2 matches. Continuing through 14,15,0,1 -> no mismatch, err_count=0.
- Hold then illegal step: obs_enable=0 with count held at 5 for 3 cycles -> no mismatch. Count then 6 with prev_en=0 -> mismatch pulse, expected=5, fail=1, err_count=1.
- Skip and reseed: enable=1, counts 7,9,10,11 -> exactly one mismatch (expected=8), err_count increments by 1 only.
- Saturation and clear (ERR_CNT_W=2): 5 injected errors -> err_count=3, fail=1. Pulse clear -> err_count=0, fail=0, locked stays 1. Clear coincident with an error -> err_count stays 0.
- MISR (macro defined): after clear, CHECK samples 1,2,3 -> signature=4'b0011. Macro undefined -> signature=0 throughout.
